jdb_dbgreq_initiator: RTL and testbench

- Requester end of the HAD pad debug-request handshake.
- Drives pad_had_jdb_req_b low on a SoC-side trigger.
- Waits for the HAD's active-low had_pad_jdb_ack_b pulse, then tracks debug residency through had_pad_jdb_pm.
- Reports completion or timeout to the SoC. Sits in the SoC debug/cross-trigger logic, clocked by tclk.

---
 rtl/jdb_dbgreq_initiator.sv | 155 +++++++++++++++
 tb/tb_jdb_dbgreq_initiator.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jdb_dbgreq_initiator.sv
// jdb_dbgreq_initiator
//   Requester side of the HAD pad debug-request handshake. A SoC trigger
//   pulls pad_had_jdb_req_b low until the HAD acknowledges (or the request
//   is cancelled or times out). The block then follows debug residency
//   through had_pad_jdb_pm and reports completion or timeout back to the SoC.
//
// Ports
//   tclk, trst_b       debug clock (rising edge) / async active-low reset
//   dbg_req_trig       single-cycle request pulse from the SoC
//   dbg_req_cancel     level; aborts an outstanding request while in REQ
//   had_pad_jdb_ack_b  active-low ack from the HAD
//   had_pad_jdb_pm     core mode: 00 run, 01 low-power, 10 debug, 11 reserved
//   pad_had_jdb_req_b  active-low debug request to the HAD (registered)
//   dbg_busy           high in any non-IDLE state
//   dbg_in_debug       high while in DEBUG
//   dbg_done           one-cycle pulse on debug exit
//   dbg_timeout        one-cycle pulse when no ack arrives within TO_CYC
//   dbg_drop_cnt       saturating count of triggers ignored while busy
module jdb_dbgreq_initiator #(
    parameter int TO_W   = 8,
    parameter int TO_CYC = 200
) (
    input  logic       tclk,
    input  logic       trst_b,
    input  logic       dbg_req_trig,
    input  logic       dbg_req_cancel,
    input  logic       had_pad_jdb_ack_b,
    input  logic [1:0] had_pad_jdb_pm,
    output logic       pad_had_jdb_req_b,
    output logic       dbg_busy,
    output logic       dbg_in_debug,
    output logic       dbg_done,
    output logic       dbg_timeout,
    output logic [3:0] dbg_drop_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DEBUG,
        S_RELEASE
    } state_e;

    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TO_CYC - 1);
    localparam logic [1:0]      PM_DEBUG = 2'b10;

    state_e          state_q, state_d;
    logic            ack_q;
    logic [TO_W-1:0] cnt_q, cnt_d;
    // Set once one non-debug pm sample has been seen in DEBUG; a second
    // consecutive one ends the debug session.
    logic            nd_q, nd_d;
    logic            req_b_q, req_b_d;
    logic            busy_q, busy_d;
    logic            in_dbg_q, in_dbg_d;
    logic            done_q, done_d;
    logic            to_q, to_d;
    logic [3:0]      drop_q, drop_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        nd_d    = nd_q;
        req_b_d = req_b_q;
        done_d  = 1'b0;
        to_d    = 1'b0;
        drop_d  = drop_q;

        // Any trigger seen outside IDLE is lost, even on the exit cycle.
        if (dbg_req_trig && (state_q != S_IDLE) && (drop_q != 4'hf))
            drop_d = drop_q + 4'd1;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (dbg_req_trig) begin
                    state_d = S_REQ;
                    req_b_d = 1'b0;
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + TO_W'(1);
                // Cancel beats ack, ack beats timeout.
                if (dbg_req_cancel) begin
                    state_d = S_RELEASE;
                    req_b_d = 1'b1;
                end else if (!ack_q) begin
                    state_d = S_DEBUG;
                    req_b_d = 1'b1;
                    nd_d    = 1'b0;
                end else if (cnt_q == TO_LAST) begin
                    state_d = S_RELEASE;
                    req_b_d = 1'b1;
                    to_d    = 1'b1;
                end
            end
            S_DEBUG: begin
                if (had_pad_jdb_pm != PM_DEBUG) begin
                    if (nd_q) begin
                        state_d = S_RELEASE;
                        done_d  = 1'b1;
                        nd_d    = 1'b0;
                    end else begin
                        nd_d = 1'b1;
                    end
                end else begin
                    nd_d = 1'b0;
                end
            end
            S_RELEASE: begin
                // Hold req_b high until the HAD has dropped its ack.
                if (ack_q)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d   = (state_d != S_IDLE);
        in_dbg_d = (state_d == S_DEBUG);
    end

    always_ff @(posedge tclk or negedge trst_b) begin
        if (!trst_b) begin
            state_q  <= S_IDLE;
            ack_q    <= 1'b1;
            cnt_q    <= '0;
            nd_q     <= 1'b0;
            req_b_q  <= 1'b1;
            busy_q   <= 1'b0;
            in_dbg_q <= 1'b0;
            done_q   <= 1'b0;
            to_q     <= 1'b0;
            drop_q   <= 4'd0;
        end else begin
            state_q  <= state_d;
            ack_q    <= had_pad_jdb_ack_b;
            cnt_q    <= cnt_d;
            nd_q     <= nd_d;
            req_b_q  <= req_b_d;
            busy_q   <= busy_d;
            in_dbg_q <= in_dbg_d;
            done_q   <= done_d;
            to_q     <= to_d;
            drop_q   <= drop_d;
        end
    end

    assign pad_had_jdb_req_b = req_b_q;
    assign dbg_busy          = busy_q;
    assign dbg_in_debug      = in_dbg_q;
    assign dbg_done          = done_q;
    assign dbg_timeout       = to_q;
    assign dbg_drop_cnt      = drop_q;

endmodule

// File: tb/tb_jdb_dbgreq_initiator.sv
// Scoreboard bench for jdb_dbgreq_initiator. Each scenario works out, from
// the handshake rules, the cycle at which every observable event must occur
// and queues it; the monitor pops and compares as events appear.
module tb_jdb_dbgreq_initiator;
    localparam int TO_W   = 8;
    localparam int TO_CYC = 200;

    logic       tclk = 1'b0;
    logic       trst_b = 1'b1;
    logic       dbg_req_trig = 1'b0;
    logic       dbg_req_cancel = 1'b0;
    logic       had_pad_jdb_ack_b = 1'b1;
    logic [1:0] had_pad_jdb_pm = 2'b00;
    logic       pad_had_jdb_req_b, dbg_busy, dbg_in_debug, dbg_done, dbg_timeout;
    logic [3:0] dbg_drop_cnt;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int exp_drops = 0;
    bit mon_en = 1'b0;

    typedef enum int {EV_REQLO, EV_REQHI, EV_DBG, EV_DONE, EV_TO} ev_e;
    typedef struct { ev_e kind; int at; } ev_t;
    ev_t exp_q[$];

    jdb_dbgreq_initiator #(.TO_W(TO_W), .TO_CYC(TO_CYC)) dut (
        .tclk              (tclk),
        .trst_b            (trst_b),
        .dbg_req_trig      (dbg_req_trig),
        .dbg_req_cancel    (dbg_req_cancel),
        .had_pad_jdb_ack_b (had_pad_jdb_ack_b),
        .had_pad_jdb_pm    (had_pad_jdb_pm),
        .pad_had_jdb_req_b (pad_had_jdb_req_b),
        .dbg_busy          (dbg_busy),
        .dbg_in_debug      (dbg_in_debug),
        .dbg_done          (dbg_done),
        .dbg_timeout       (dbg_timeout),
        .dbg_drop_cnt      (dbg_drop_cnt)
    );

    always #5 tclk = ~tclk;
    always @(posedge tclk) cyc++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(ev_e k, int at);
        ev_t e;
        e.kind = k;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    task automatic see(ev_e k);
        ev_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event: got %s at cycle %0d, required none", k.name(), cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.at != cyc) begin
                fails++;
                $display("FAIL event: got %s at cycle %0d, required %s at cycle %0d",
                         k.name(), cyc, e.kind.name(), e.at);
            end
        end
    endtask

    // Monitor: outputs sampled on the falling edge.
    logic req_prev = 1'b1;
    logic dbg_prev = 1'b0;
    always @(negedge tclk) begin
        if (mon_en) begin
            if (req_prev && !pad_had_jdb_req_b) see(EV_REQLO);
            if (!req_prev && pad_had_jdb_req_b) see(EV_REQHI);
            if (!dbg_prev && dbg_in_debug)      see(EV_DBG);
            if (dbg_done)                       see(EV_DONE);
            if (dbg_timeout)                    see(EV_TO);
        end
        req_prev = pad_had_jdb_req_b;
        dbg_prev = dbg_in_debug;
    end

    task automatic step();
        @(posedge tclk);
        #1;
    endtask

    task automatic note_drop();
        exp_drops = (exp_drops < 15) ? exp_drops + 1 : 15;
    endtask

    // Full handshake. Ack is driven low for two cycles starting at a; the
    // request is seen two cycles after ack falls, but never before the
    // second cycle after the trigger. pm leaves debug for cycles p and p+1.
    // drop_mode: 0 none, 1 random triggers in DEBUG, 2 seventeen in a row.
    task automatic run_normal(bit coll, bit glitch, int drop_mode);
        int t, a, d, p, g;
        t = cyc + 1;
        a = coll ? t + TO_CYC - 1 : t - 1 + int'($urandom_range(0, 20));
        d = (a + 2 > t + 2) ? a + 2 : t + 2;
        p = d + 2 + int'($urandom_range(0, 20));
        if (drop_mode == 2 && p < d + 18) p = d + 18;
        g = d + int'($urandom_range(0, p - d - 2));
        push(EV_REQLO, t + 1);
        push(EV_REQHI, d);
        push(EV_DBG, d);
        push(EV_DONE, p + 2);
        for (int c = t - 1; c <= p + 3; c++) begin
            if (c != t - 1) step();
            dbg_req_trig      = (c == t);
            had_pad_jdb_ack_b = !(c == a || c == a + 1);
            had_pad_jdb_pm    = (c < p && !(glitch && c == g)) ? 2'b10 : 2'b00;
            if (drop_mode == 1 && c >= d && c < p && $urandom_range(0, 2) == 0) begin
                dbg_req_trig = 1'b1;
                note_drop();
            end
            if (drop_mode == 2 && c >= d && c < d + 17) begin
                dbg_req_trig = 1'b1;
                note_drop();
            end
            if (c == d + 1) chk("in_debug_set", int'(dbg_in_debug), 1);
            if (c == p + 2) chk("in_debug_clr", int'(dbg_in_debug), 0);
        end
        dbg_req_trig = 1'b0;
        chk("idle_after_done", int'(dbg_busy), 0);
        chk("drop_cnt", int'(dbg_drop_cnt), exp_drops);
    endtask

    task automatic run_timeout();
        int t;
        t = cyc + 1;
        push(EV_REQLO, t + 1);
        push(EV_REQHI, t + 1 + TO_CYC);
        push(EV_TO, t + 1 + TO_CYC);
        for (int c = t - 1; c <= t + 2 + TO_CYC; c++) begin
            if (c != t - 1) step();
            dbg_req_trig      = (c == t);
            had_pad_jdb_ack_b = 1'b1;
            had_pad_jdb_pm    = 2'($urandom_range(0, 3));
        end
        had_pad_jdb_pm = 2'b00;
        chk("idle_after_timeout", int'(dbg_busy), 0);
    endtask

    // Cancel held on the k-th REQ cycle; optional trigger while releasing.
    task automatic run_cancel(int k, bit trig_in_rel);
        int t, cc;
        t  = cyc + 1;
        cc = t + k;
        push(EV_REQLO, t + 1);
        push(EV_REQHI, cc + 1);
        for (int c = t - 1; c <= cc + 2; c++) begin
            if (c != t - 1) step();
            dbg_req_trig      = (c == t) || (trig_in_rel && c == cc + 1);
            dbg_req_cancel    = (c == cc);
            had_pad_jdb_ack_b = 1'b1;
        end
        if (trig_in_rel) note_drop();
        dbg_req_trig = 1'b0;
        chk("idle_after_cancel", int'(dbg_busy), 0);
        chk("drop_cnt_cancel", int'(dbg_drop_cnt), exp_drops);
    endtask

    initial begin
        #1 trst_b = 1'b0;
        #2;
        chk("rst_req_b", int'(pad_had_jdb_req_b), 1);
        chk("rst_busy", int'(dbg_busy), 0);
        chk("rst_in_debug", int'(dbg_in_debug), 0);
        chk("rst_done", int'(dbg_done), 0);
        chk("rst_timeout", int'(dbg_timeout), 0);
        chk("rst_drop", int'(dbg_drop_cnt), 0);
        step();
        step();
        trst_b = 1'b1;
        mon_en = 1'b1;
        step();

        run_normal(1'b0, 1'b0, 0);
        run_normal(1'b0, 1'b1, 0);
        run_cancel(3, 1'b0);
        run_timeout();
        run_normal(1'b1, 1'b0, 0);
        for (int i = 0; i < 15; i++) begin
            case ($urandom_range(0, 6))
                0, 1, 2: run_normal(1'b0, 1'($urandom_range(0, 1)), 1);
                3, 4:    run_cancel(int'($urandom_range(1, 20)), 1'($urandom_range(0, 1)));
                5:       run_timeout();
                default: run_normal(1'b1, 1'($urandom_range(0, 1)), 0);
            endcase
            repeat ($urandom_range(0, 3)) step();
        end
        run_normal(1'b0, 1'b0, 2);
        chk("drop_saturated", int'(dbg_drop_cnt), 15);

        // Reset in the middle of REQ.
        begin
            int t;
            t = cyc + 1;
            push(EV_REQLO, t + 1);
            for (int c = t - 1; c <= t + 3; c++) begin
                if (c != t - 1) step();
                dbg_req_trig = (c == t);
            end
            chk("req_low_before_rst", int'(pad_had_jdb_req_b), 0);
            #2;
            mon_en = 1'b0;
            trst_b = 1'b0;
            #1;
            chk("midrst_req_b", int'(pad_had_jdb_req_b), 1);
            chk("midrst_busy", int'(dbg_busy), 0);
            chk("midrst_in_debug", int'(dbg_in_debug), 0);
            chk("midrst_done", int'(dbg_done), 0);
            chk("midrst_timeout", int'(dbg_timeout), 0);
            chk("midrst_drop", int'(dbg_drop_cnt), 0);
            exp_drops = 0;
            step();
            step();
            trst_b = 1'b1;
            step();
            mon_en = 1'b1;
        end

        run_normal(1'b0, 1'b0, 1);
        repeat (4) step();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
